// File: rtl/fifo_word_packer.sv
// Drains bytes from the 8-bit buffer FIFO and packs PACK bytes little-endian into one word.
// The word is offered on a valid/ready handshake; flush pushes out a partially filled word.

module fifo_word_packer_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (we)    q <= d;
    end
endmodule

module fifo_word_packer #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4,
    parameter int CNT_W  = $clog2(PACK) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        buf_out,
    input  logic                     buf_empty,
    output logic                     rd_en,
    input  logic                     flush,
    output logic [DATA_W*PACK-1:0]   word_data,
    output logic [CNT_W-1:0]         word_bytes,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     busy
);
    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [CNT_W:0] PACK_W = (CNT_W+1)'(PACK);

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     inflight;
    logic                     flush_pend;
    logic [PACK-1:0][DATA_W-1:0] lane;
    logic                     hs;
    logic                     cap_full;
    logic                     flush_now;
    logic                     emit_flush;
    logic [CNT_W:0]           fill_lvl;

    always_comb begin
        state_nxt  = state;
        hs         = word_valid && word_ready;
        fill_lvl   = {1'b0, cnt} + (CNT_W+1)'(inflight);
        cap_full   = inflight && (fill_lvl == PACK_W);
        // a flush that will actually do something; it also stalls reads in its own cycle
        flush_now  = flush && (state == FILL) && (cnt != '0 || inflight);
        emit_flush = (state == FILL) && !inflight && (flush_pend || flush_now);
        rd_en      = !rst && (state == FILL) && !buf_empty && (fill_lvl < PACK_W)
                     && !flush_pend && !flush_now;
        case (state)
            FILL: if (cap_full || emit_flush) state_nxt = HOLD;
            HOLD: if (hs) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            word_valid <= 1'b0;
            word_bytes <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (hs) begin
                word_valid <= 1'b0;
                cnt        <= '0;
            end else if (inflight) begin
                cnt <= cnt + CNT_W'(1);
                if (cap_full) begin
                    word_valid <= 1'b1;
                    word_bytes <= CNT_W'(PACK);
                end
            end else if (emit_flush) begin
                word_valid <= 1'b1;
                word_bytes <= cnt;
            end
            // flush arriving with a byte in flight waits one cycle for that byte to land
            if (emit_flush)
                flush_pend <= 1'b0;
            else if (flush_now && inflight && !cap_full)
                flush_pend <= 1'b1;
        end
    end

    for (genvar i = 0; i < PACK; i++) begin : g_lane
        fifo_word_packer_lane #(.DATA_W(DATA_W)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (hs),
            .we  (inflight && (cnt == CNT_W'(i))),
            .d   (buf_out),
            .q   (lane[i])
        );
    end

    assign word_data = lane;
    assign busy      = (cnt != '0) || inflight || word_valid;
endmodule
